hls_fp32_sub_arb: RTL

//  Shares one fixed-latency fp32 subtract core between NREQ requesters. Each issue is

---
 rtl/hls_fp32_sub_arb_if.sv | 48 ++++
 rtl/hls_fp32_sub_arb.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/hls_fp32_sub_arb_if.sv
// ---------------------------------------------------------------------------
// hls_fp32_sub_arb_if
//   Bundles the signals of hls_fp32_sub_arb: the requester channels, the
//   shared fp32 subtract core interface, the tagged result channel and the
//   status flags.
//
//   Ports (modport slave = arbiter side, master = environment side)
//     req_vld / req_a / req_b / req_rdy   per-requester operands + accept
//     core_in_vld / core_a_dat / core_b_dat   issue to the shared core
//     core_o_vld / core_o_dat                 core result
//     o_vld / o_dat / o_tag / o_rdy           tagged result channel
//     busy / err                              status
// ---------------------------------------------------------------------------
interface hls_fp32_sub_arb_if #(
   parameter int NREQ  = 4,
   parameter int TAG_W = 2
);
   logic [NREQ-1:0]    req_vld;
   logic [NREQ*32-1:0] req_a;
   logic [NREQ*32-1:0] req_b;
   logic [NREQ-1:0]    req_rdy;

   logic               core_in_vld;
   logic [31:0]        core_a_dat;
   logic [31:0]        core_b_dat;
   logic               core_o_vld;
   logic [31:0]        core_o_dat;

   logic               o_vld;
   logic [31:0]        o_dat;
   logic [TAG_W-1:0]   o_tag;
   logic               o_rdy;

   logic               busy;
   logic               err;

   modport slave (
      input  req_vld, req_a, req_b, core_o_vld, core_o_dat, o_rdy,
      output req_rdy, core_in_vld, core_a_dat, core_b_dat,
             o_vld, o_dat, o_tag, busy, err
   );

   modport master (
      output req_vld, req_a, req_b, core_o_vld, core_o_dat, o_rdy,
      input  req_rdy, core_in_vld, core_a_dat, core_b_dat,
             o_vld, o_dat, o_tag, busy, err
   );
endinterface

// File: rtl/hls_fp32_sub_arb.sv
// ---------------------------------------------------------------------------
// hls_fp32_sub_arb
//   Shares one fixed-latency fp32 subtract core between NREQ requesters.
//   A round-robin arbiter issues at most one operation per cycle, tagged with
//   the requester index. A tag pipe tracks the core latency, and completed
//   results are buffered in a FIFO and returned on one tagged output channel.
//   Issue is credit-gated (FIFO entries + ops in flight < OUT_DEPTH), so the
//   core never needs to stall and no result is lost.
//
//   Ports
//     nvdla_core_clk    clock
//     nvdla_core_rstn   asynchronous active-low reset
//     bus (slave)       requester channels, core interface, result channel,
//                       busy and sticky err status
// ---------------------------------------------------------------------------
module hls_fp32_sub_arb #(
   parameter int NREQ      = 4,
   parameter int TAG_W     = 2,
   parameter int CORE_LAT  = 3,
   parameter int OUT_DEPTH = 4
) (
   input  logic              nvdla_core_clk,
   input  logic              nvdla_core_rstn,
   hls_fp32_sub_arb_if.slave bus
);

   localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CNT_W = $clog2(OUT_DEPTH + 1);
   localparam int INF_W = $clog2(CORE_LAT + 1);

   typedef struct packed {
      logic             v;
      logic [TAG_W-1:0] tag;
   } tag_stage_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [31:0]      dat;
   } fifo_entry_t;

   // State
   logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
   tag_stage_t       pipe_q [CORE_LAT];
   logic [INF_W-1:0] inflight_q, inflight_d;
   logic [INF_W-1:0] ign_q, ign_d;
   logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   fifo_entry_t      mem_q [OUT_DEPTH];
   logic [31:0]      last_a_q, last_b_q;
   logic             err_q, err_d;

   // Combinational
   logic             credit_ok, found, issue;
   logic [TAG_W-1:0] gnt_idx, cand;
   logic [31:0]      gnt_a, gnt_b;
   tag_stage_t       tail;
   logic             fifo_empty, fifo_full;
   logic             push, push_ok, pop, mismatch;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Credit counts both buffered results and results still inside the core,
   // so every issued op is guaranteed a FIFO slot when it emerges.
   assign credit_ok = (32'(fifo_cnt_q) + 32'(inflight_q)) < 32'(OUT_DEPTH);

   // Round-robin scan starting at rr_ptr_q.
   always_comb begin
      // NOTE: every variable gets a default before the loop so no path leaves
      // it unassigned, which would otherwise infer a latch.
      found   = 1'b0;
      gnt_idx = rr_ptr_q;
      cand    = rr_ptr_q;
      for (int i = 0; i < NREQ; i++) begin
         cand = TAG_W'((int'(rr_ptr_q) + i) % NREQ);
         if (!found && bus.req_vld[cand]) begin
            found   = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   assign issue = credit_ok & found;
   assign gnt_a = bus.req_a[32*int'(gnt_idx) +: 32];
   assign gnt_b = bus.req_b[32*int'(gnt_idx) +: 32];

   assign bus.req_rdy     = issue ? (NREQ'(1) << gnt_idx) : '0;
   assign bus.core_in_vld = issue;
   // Operands hold their last issued value while idle to avoid needless toggling.
   assign bus.core_a_dat  = issue ? gnt_a : last_a_q;
   assign bus.core_b_dat  = issue ? gnt_b : last_b_q;

   // Tail of the tag pipe lines up with the core output of the same op.
   assign tail       = pipe_q[CORE_LAT-1];
   assign fifo_empty = (fifo_cnt_q == '0);
   assign fifo_full  = (fifo_cnt_q == CNT_W'(OUT_DEPTH));
   assign push       = tail.v & bus.core_o_vld;
   assign push_ok    = push & ~fifo_full;
   assign mismatch   = tail.v ^ bus.core_o_vld;
   assign pop        = ~fifo_empty & bus.o_rdy;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (issue) begin
         rr_ptr_d = (gnt_idx == TAG_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      inflight_d = inflight_q + INF_W'(issue) - INF_W'(tail.v);
      // Results from ops issued before a reset may still leave the core during
      // the first CORE_LAT cycles; those strobes must not raise err.
      ign_d      = (ign_q != '0) ? ign_q - 1'b1 : ign_q;
      fifo_cnt_d = fifo_cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
      wr_ptr_d   = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      err_d      = err_q | (mismatch & (ign_q == '0)) | (push & fifo_full);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         rr_ptr_q   <= '0;
         inflight_q <= '0;
         ign_q      <= INF_W'(CORE_LAT);
         fifo_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         last_a_q   <= '0;
         last_b_q   <= '0;
         err_q      <= 1'b0;
         for (int i = 0; i < CORE_LAT; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         inflight_q <= inflight_d;
         ign_q      <= ign_d;
         fifo_cnt_q <= fifo_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         err_q      <= err_d;
         pipe_q[0]  <= '{v: issue, tag: gnt_idx};
         for (int i = 1; i < CORE_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
         if (issue) begin
            last_a_q <= gnt_a;
            last_b_q <= gnt_b;
         end
      end
   end

   // NOTE: the FIFO storage is deliberately not reset; validity is carried by
   // the reset pointers and count, and leaving it out keeps it plain RAM.
   always_ff @(posedge nvdla_core_clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= '{tag: tail.tag, dat: bus.core_o_dat};
      end
   end

   assign bus.o_vld = ~fifo_empty;
   assign bus.o_dat = mem_q[rd_ptr_q].dat;
   assign bus.o_tag = mem_q[rd_ptr_q].tag;
   assign bus.busy  = (inflight_q != '0) | ~fifo_empty;
   assign bus.err   = err_q;

   // The credit check makes a push into a full FIFO impossible.
   a_no_push_when_full : assert property (
      @(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn) !(push && fifo_full)
   );

endmodule
